debug_uart_rx: RTL and testbench
================================

DEBUG_UART_RX -- requirements
Module: debug_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 74250000, meaning the clk_74a frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate; 8N1 framing, LSB first.
REQ-003 SHALL have port clk_74a, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port uart_rx, input, 1, asynchronous serial line from the debug key pin, idle high.
REQ-006 SHALL have port rx_data, output, 8, received byte.
REQ-007 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready, input, 1, consumer accepts rx_data.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a good byte is dropped.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer; both flops reset to 1.
REQ-013 SHALL derive an oversample tick at 16x BAUD: DIV = max(1, (CLK_HZ + 8*BAUD) / (16*BAUD)); divider counts 0..DIV-1, ticks on wrap, held at 0 in IDLE.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY under REQ-025).
REQ-015 IDLE -> START on a synchronized falling edge (previous 1, current 0); the tick counter and bit counter clear.
REQ-016 START: on the 8th tick, sample the line; 1 -> IDLE (glitch, no error pulse); 0 -> DATA.
REQ-017 DATA: sample every 16th tick, shift in LSB first; after the 8th bit -> STOP.
REQ-018 STOP: sample on the 16th tick; 1 -> deliver the byte and go to IDLE in the same cycle, so the next start edge is caught back-to-back.
REQ-019 STOP sample 0 -> frame_err pulses for one cycle, discard the byte, go to WAIT_HIGH; WAIT_HIGH -> IDLE when the synchronized line reads 1.
REQ-020 Delivery: if rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle, load rx_data and hold rx_valid=1 from the next cycle.
REQ-021 Delivery with rx_valid=1 and rx_ready=0 -> overrun pulses for one cycle; the new byte is dropped; old rx_data and rx_valid are unchanged.
REQ-022 rx_valid=1 with rx_ready=1 and no delivery -> rx_valid clears next cycle; rx_data SHALL stay stable while rx_valid=1.

Reset
REQ-023 reset_n low SHALL immediately force: FSM IDLE, counters 0, synchronizer 1, rx_valid 0, rx_data 0x00, frame_err 0, overrun 0, busy 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no pulses; after release the first falling edge is treated as a start bit.

Configuration
REQ-025 With macro DEBUG_UART_RX_PARITY_EN defined: 8E1 framing, a PARITY state between DATA and STOP, output port parity_err (1-bit pulse); a parity mismatch pulses parity_err, drops the byte and still checks the stop bit.
REQ-026 Without DEBUG_UART_RX_PARITY_EN: 8N1 only; no PARITY state and no parity_err port.

Structure
REQ-027 Package debug_uart_pkg SHALL hold: the state enum, OSR=16 constant, the DIV computation function, DATA_BITS=8.
REQ-028 The divider SHALL be a sub-module uart_baud_tick (inputs: clock, reset, enable; output: tick).

Verification
Bench setup for REQ-029..REQ-033: CLK_HZ=7372800, BAUD=115200, so DIV=4 and one bit = 64 clocks.
REQ-029 Send 0xA5, rx_ready=1 -> rx_valid for one cycle, rx_data=0xA5, no frame_err or overrun.
REQ-030 Send 0x3C then 0x81 back-to-back, rx_ready=0 -> rx_data=0x3C is held, overrun pulses once at the second stop sample.
REQ-031 Send 0x55 with the stop bit low, then hold the line low for 20 bits -> frame_err pulses once, rx_valid stays 0, busy stays 1 until the line returns high.
REQ-032 A 20-clock low glitch on an idle line -> busy pulses, returns to IDLE, no rx_valid or error.
REQ-033 reset_n low during bit 4 of 0xFF, then send 0x12 -> only 0x12 is delivered; all outputs are 0 during reset.
REQ-034 With DEBUG_UART_RX_PARITY_EN defined, send 0x07 with odd parity -> parity_err pulses, rx_valid stays 0.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// ============================================================================
// Module      : debug_uart_pkg
// Description : Shared types and constants for the debug UART receiver.
//               DEBUG_UART_RX_PARITY_EN adds the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_uart_pkg;

    localparam int OSR       = 16;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
`ifdef DEBUG_UART_RX_PARITY_EN
        ,
        ST_PARITY    = 3'd5
`endif
    } rx_state_e;

    // Rounded clocks-per-oversample-tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + (OSR / 2) * baud) / (OSR * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Oversample tick generator; counter parked at zero when idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int c_cw = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_cw-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == c_cw'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && w_wrap;

endmodule

`default_nettype wire

// File: rtl/debug_uart_rx.sv
// ============================================================================
// Module      : debug_uart_rx
// Description : 16x-oversampled 8N1 receiver with valid/ready output and
//               error pulses. DEBUG_UART_RX_PARITY_EN selects 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_uart_rx
    import debug_uart_pkg::*;
#(
    parameter int CLK_HZ = 74250000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef DEBUG_UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int c_div = calc_div(CLK_HZ, BAUD);
    localparam int c_tw  = $clog2(OSR);
    localparam int c_bw  = $clog2(DATA_BITS);

    rx_state_e              r_state, w_state_next;
    logic                   r_sync1, r_sync2, r_prev;
    logic [c_tw-1:0]        r_tcnt, w_tcnt_next;
    logic [c_bw-1:0]        r_bcnt, w_bcnt_next;
    logic [DATA_BITS-1:0]   r_shift, w_shift_next;
    logic                   r_frame_err, w_frame_bad;
    logic                   r_overrun;
    logic                   r_valid;
    logic [7:0]             r_data;
    logic                   w_tick, w_deliver, w_mid, w_end;
`ifdef DEBUG_UART_RX_PARITY_EN
    logic                   r_par_bad, w_par_bad_next;
    logic                   r_parity_err, w_parity_bad;
`endif

    uart_baud_tick #(
        .DIV    (c_div)
    ) u_baud_tick (
        .clk    (clk_74a),
        .rst_n  (reset_n),
        .i_en   (r_state != ST_IDLE),
        .o_tick (w_tick)
    );

    assign w_mid = w_tick && (r_tcnt == c_tw'(OSR / 2 - 1));
    assign w_end = w_tick && (r_tcnt == c_tw'(OSR - 1));

    always_comb begin
        w_state_next = r_state;
        w_tcnt_next  = w_tick ? r_tcnt + 1'b1 : r_tcnt;
        w_bcnt_next  = r_bcnt;
        w_shift_next = r_shift;
        w_deliver    = 1'b0;
        w_frame_bad  = 1'b0;
`ifdef DEBUG_UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_parity_bad   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tcnt_next = '0;
                w_bcnt_next = '0;
`ifdef DEBUG_UART_RX_PARITY_EN
                w_par_bad_next = 1'b0;
`endif
                if (r_prev && !r_sync2) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // Mid start bit: realign so later samples land mid-bit.
                if (w_mid) begin
                    w_tcnt_next  = '0;
                    w_state_next = r_sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_end) begin
                    w_shift_next = {r_sync2, r_shift[DATA_BITS-1:1]};
                    w_bcnt_next  = r_bcnt + 1'b1;
                    if (r_bcnt == c_bw'(DATA_BITS - 1)) begin
`ifdef DEBUG_UART_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef DEBUG_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_end) begin
                    w_parity_bad   = (^r_shift) ^ r_sync2;
                    w_par_bad_next = w_parity_bad;
                    w_state_next   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_end) begin
                    if (r_sync2) begin
`ifdef DEBUG_UART_RX_PARITY_EN
                        w_deliver = !r_par_bad;
`else
                        w_deliver = 1'b1;
`endif
                        w_state_next = ST_IDLE;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_state_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                w_tcnt_next = '0;
                if (r_sync2) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef DEBUG_UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1     <= uart_rx;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_state     <= w_state_next;
            r_tcnt      <= w_tcnt_next;
            r_bcnt      <= w_bcnt_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_frame_bad;
`ifdef DEBUG_UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad_next;
            r_parity_err <= w_parity_bad;
`endif
        end
    end

    // Output holding register: a held byte is never overwritten.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);
`ifdef DEBUG_UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debug_uart_rx.sv
// ============================================================================
// Module      : tb_debug_uart_rx
// Description : Directed self-checking bench for debug_uart_rx at DIV=4
//               (64 clocks per bit). Honours DEBUG_UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_uart_rx;

    localparam int c_bit = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef DEBUG_UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    int n_fe = 0, n_ov = 0, n_pe = 0, n_vcyc = 0, n_vrise = 0, n_busy = 0;
    logic       r_pv = 1'b0;
    logic [7:0] got[$];

    int b_fe, b_ov, b_pe, b_vcyc, b_vrise, b_busy, b_got;

    always #5 clk = ~clk;

    debug_uart_rx #(
        .CLK_HZ    (7372800),
        .BAUD      (115200)
    ) dut (
        .clk_74a   (clk),
        .reset_n   (reset_n),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef DEBUG_UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    // Event counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err) n_fe <= n_fe + 1;
            if (overrun)   n_ov <= n_ov + 1;
`ifdef DEBUG_UART_RX_PARITY_EN
            if (parity_err) n_pe <= n_pe + 1;
`endif
            if (rx_valid)  n_vcyc <= n_vcyc + 1;
            if (rx_valid && !r_pv) n_vrise <= n_vrise + 1;
            if (busy)      n_busy <= n_busy + 1;
            if (rx_valid && rx_ready) got.push_back(rx_data);
            r_pv <= rx_valid;
        end else begin
            r_pv <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_fe = n_fe; b_ov = n_ov; b_pe = n_pe; b_vcyc = n_vcyc;
        b_vrise = n_vrise; b_busy = n_busy; b_got = got.size();
    endtask

    // Line is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        uart_rx = 1'b0;
        tick(c_bit);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(c_bit);
        end
`ifdef DEBUG_UART_RX_PARITY_EN
        uart_rx = (^d) ^ par_flip;
        tick(c_bit);
`else
        if (par_flip) uart_rx = 1'b1;
`endif
        uart_rx = stop;
        tick(c_bit);
    endtask

    function automatic logic [7:0] got_at(input int idx);
        if (idx < got.size()) return got[idx];
        return 8'hxx;
    endfunction

    initial begin
        reset_n  = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        #1;
        check("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("reset_rx_data",   {24'd0, rx_data},   32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun",   {31'd0, overrun},   32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        tick(5);
        reset_n = 1'b1;
        tick(5);

        // Single byte, consumer ready.
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(10);
        check("a5_valid_rises",  n_vrise - b_vrise, 1);
        check("a5_valid_cycles", n_vcyc - b_vcyc,   1);
        check("a5_bytes",        got.size() - b_got, 1);
        check("a5_data",         {24'd0, got_at(b_got)}, 32'hA5);
        check("a5_frame_err",    n_fe - b_fe, 0);
        check("a5_overrun",      n_ov - b_ov, 0);
        check("a5_busy_idle",    {31'd0, busy}, 32'd0);

        // Back-to-back bytes, consumer stalled.
        rx_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        tick(10);
        check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check("ovr_data_held",  {24'd0, rx_data},  32'h3C);
        check("ovr_pulses",     n_ov - b_ov, 1);
        check("ovr_frame_err",  n_fe - b_fe, 0);
        rx_ready = 1'b1;
        tick(5);
        check("ovr_drained",    {31'd0, rx_valid}, 32'd0);
        check("ovr_bytes",      got.size() - b_got, 1);
        check("ovr_byte_seen",  {24'd0, got_at(b_got)}, 32'h3C);

        // Bad stop bit, then line stuck low.
        snap();
        send_frame(8'h55, 1'b0, 1'b0);
        uart_rx = 1'b0;
        tick(20 * c_bit);
        check("fe_pulses",      n_fe - b_fe, 1);
        check("fe_no_valid",    n_vcyc - b_vcyc, 0);
        check("fe_busy_low",    {31'd0, busy}, 32'd1);
        uart_rx = 1'b1;
        tick(5);
        check("fe_busy_release", {31'd0, busy}, 32'd0);
        check("fe_no_more",     n_fe - b_fe, 1);

        // Short glitch on an idle line.
        tick(c_bit);
        snap();
        uart_rx = 1'b0;
        tick(20);
        uart_rx = 1'b1;
        tick(60);
        check("gl_busy_seen",   {31'd0, (n_busy != b_busy)}, 32'd1);
        check("gl_busy_idle",   {31'd0, busy}, 32'd0);
        check("gl_no_valid",    n_vcyc - b_vcyc, 0);
        check("gl_no_fe",       n_fe - b_fe, 0);

        // Reset in the middle of bit 4 of 0xFF, then a clean 0x12.
        snap();
        uart_rx = 1'b0;
        tick(c_bit);
        uart_rx = 1'b1;
        tick(4 * c_bit + c_bit / 2);
        check("rst_pre_busy",   {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_busy",       {31'd0, busy},      32'd0);
        check("rst_valid",      {31'd0, rx_valid},  32'd0);
        check("rst_data",       {24'd0, rx_data},   32'd0);
        check("rst_fe",         {31'd0, frame_err}, 32'd0);
        check("rst_ovr",        {31'd0, overrun},   32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(5 * c_bit);
        send_frame(8'h12, 1'b1, 1'b0);
        tick(10);
        check("rst_bytes",      got.size() - b_got, 1);
        check("rst_byte",       {24'd0, got_at(b_got)}, 32'h12);
        check("rst_no_fe",      n_fe - b_fe, 0);
        check("rst_no_ovr",     n_ov - b_ov, 0);

`ifdef DEBUG_UART_RX_PARITY_EN
        // Wrong parity bit on 0x07.
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        tick(10);
        check("par_pulses",     n_pe - b_pe, 1);
        check("par_no_valid",   n_vcyc - b_vcyc, 0);
        check("par_no_fe",      n_fe - b_fe, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
